// File: rtl/bridge_pkg.sv
// bridge_pkg: address map and select encoding shared by the bus bridge
package bridge_pkg;
  localparam logic [19:0] PERIPH_BASE_HI = 20'hFFFFF;
  localparam logic [9:0]  TUBE_OFF       = 10'h000;
  localparam logic [9:0]  TIMER_OFF      = 10'h008;
  localparam logic [9:0]  LED_OFF        = 10'h018;
  localparam logic [9:0]  SW_OFF         = 10'h01C;
  localparam logic [9:0]  BTN_OFF        = 10'h01E;
  typedef enum logic [2:0] {
    SEL_DRAM, SEL_TUBE, SEL_TIMER, SEL_LED, SEL_SW, SEL_BTN, SEL_NONE
  } sel_e;
endpackage

// File: rtl/bus_bridge_seg7_decoder.sv
// seg7_decoder: hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
module seg7_decoder (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // lookup table of the sixteen hex glyphs
  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

// File: rtl/bus_bridge.sv
// bus_bridge: CPU data-bus decoder routing word accesses to DRAM or on-chip peripherals
module bus_bridge
  import bridge_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic [13:0] dram_addr,
  output logic        dram_we,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw_i,
  input  logic [4:0]  btn_i,
  output logic [23:0] led_o,
  output logic [7:0]  dn_an_o,
  output logic [7:0]  dn_seg_o
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  sel_e sel;
  logic [23:0] led_q, led_d;
  logic [31:0] tube_q, tube_d;
  logic [31:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0] idx_q, idx_d;
  logic [SYNC_STAGES-1:0][23:0] sw_q;
  logic [SYNC_STAGES-1:0][4:0] btn_q;
  logic [6:0] seg;
  logic unused_addr;
  assign unused_addr = ^cpu_addr[1:0];
  assign dram_addr  = cpu_addr[15:2];
  assign dram_wdata = cpu_wdata;
  assign dram_we    = cpu_wen & (sel == SEL_DRAM);
  assign led_o      = led_q;
  assign dn_an_o    = ~(8'b1 << idx_q);
  assign dn_seg_o   = {1'b1, seg};
  seg7_decoder u_seg (.nib_i(tube_q[{idx_q, 2'b00} +: 4]), .seg_o(seg));
  // address decode on the upper page and word offset
  always_comb begin
    sel = cpu_addr[31:12] != PERIPH_BASE_HI ? SEL_DRAM :
          cpu_addr[11:2] == TUBE_OFF  ? SEL_TUBE  :
          cpu_addr[11:2] == TIMER_OFF ? SEL_TIMER :
          cpu_addr[11:2] == LED_OFF   ? SEL_LED   :
          cpu_addr[11:2] == SW_OFF    ? SEL_SW    :
          cpu_addr[11:2] == BTN_OFF   ? SEL_BTN   : SEL_NONE;
  end
  // combinational read mux returning pre-write register values
  always_comb begin
    cpu_rdata = sel == SEL_DRAM  ? dram_rdata :
                sel == SEL_TUBE  ? tube_q :
                sel == SEL_TIMER ? timer_q :
                sel == SEL_LED   ? {8'h0, led_q} :
                sel == SEL_SW    ? {8'h0, sw_q[SYNC_STAGES-1]} :
                sel == SEL_BTN   ? {27'h0, btn_q[SYNC_STAGES-1]} : 32'h0;
  end
  // next-state for writable registers, timer and scan engine
  always_comb begin
    led_d   = (cpu_wen && sel == SEL_LED)   ? cpu_wdata[23:0] : led_q;
    tube_d  = (cpu_wen && sel == SEL_TUBE)  ? cpu_wdata : tube_q;
    timer_d = (cpu_wen && sel == SEL_TIMER) ? cpu_wdata : timer_q + 32'd1;
    div_d   = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    idx_d   = (div_q == DIV_MAX) ? idx_q + 3'd1 : idx_q;
  end
  // state registers and input synchronisers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q   <= '0;
      tube_q  <= '0;
      timer_q <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      sw_q    <= '0;
      btn_q   <= '0;
    end else begin
      led_q   <= led_d;
      tube_q  <= tube_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sw_q    <= {sw_q[SYNC_STAGES-2:0], sw_i};
      btn_q   <= {btn_q[SYNC_STAGES-2:0], btn_i};
    end
  end
endmodule

// File: tb/tb_bus_bridge.sv
// tb_bus_bridge: directed self-checking bench for bus_bridge
module tb_bus_bridge;
  logic        clk_i = 0;
  logic        rst_i = 1;
  logic [31:0] cpu_addr = 0;
  logic        cpu_wen = 0;
  logic [31:0] cpu_wdata = 0;
  logic [31:0] cpu_rdata;
  logic [13:0] dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata = 0;
  logic [23:0] sw_i = 0;
  logic [4:0]  btn_i = 0;
  logic [23:0] led_o;
  logic [7:0]  dn_an_o;
  logic [7:0]  dn_seg_o;
  int checks = 0;
  int errors = 0;
  logic [7:0] an_tab [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
  logic [7:0] seg_tab[9] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'hF9};

  bus_bridge #(.SCAN_DIV(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dram_addr(dram_addr),
    .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw_i(sw_i), .btn_i(btn_i), .led_o(led_o), .dn_an_o(dn_an_o), .dn_seg_o(dn_seg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    #2;
    chk("rst_led", {8'h0, led_o}, 32'h0);
    chk("rst_an", {24'h0, dn_an_o}, 32'hFE);
    chk("rst_seg", {24'h0, dn_seg_o}, 32'hC0);
    tick();
    rst_i = 0;
    // DRAM write then read
    cpu_addr = 32'h0000_0104; cpu_wen = 1; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("dram_addr", {18'h0, dram_addr}, 32'h041);
    chk("dram_we", {31'h0, dram_we}, 32'h1);
    chk("dram_wdata", dram_wdata, 32'hDEADBEEF);
    tick();
    cpu_wen = 0; dram_rdata = 32'h12345678;
    #1;
    chk("dram_rd", cpu_rdata, 32'h12345678);
    chk("dram_led", {8'h0, led_o}, 32'h0);
    cpu_addr = 32'hFFFF_F000; #1;
    chk("dram_tube", cpu_rdata, 32'h0);
    cpu_addr = 32'hFFFE_F060; cpu_wen = 1; #1;
    chk("near_miss_we", {31'h0, dram_we}, 32'h1);
    chk("near_miss_rd", cpu_rdata, 32'h12345678);
    tick();
    cpu_wen = 0;
    chk("near_miss_led", {8'h0, led_o}, 32'h0);
    // LED write
    cpu_addr = 32'hFFFF_F060; cpu_wen = 1; cpu_wdata = 32'h00A5A5A5;
    #1;
    chk("led_pre", cpu_rdata, 32'h0);
    chk("led_we0", {31'h0, dram_we}, 32'h0);
    tick();
    cpu_wen = 0;
    #1;
    chk("led_o", {8'h0, led_o}, 32'hA5A5A5);
    chk("led_rd", cpu_rdata, 32'h00A5A5A5);
    chk("led_we1", {31'h0, dram_we}, 32'h0);
    // switch/button synchronisers
    sw_i = 24'h00F00F; btn_i = 5'h15; cpu_addr = 32'hFFFF_F070;
    #1;
    chk("sw_c0", cpu_rdata, 32'h0);
    tick();
    chk("sw_c1", cpu_rdata, 32'h0);
    tick();
    chk("sw_c2", cpu_rdata, 32'h00F00F);
    cpu_wen = 1; cpu_wdata = 32'hFFFFFFFF;
    tick();
    cpu_wen = 0;
    #1;
    chk("sw_wr_ign", cpu_rdata, 32'h00F00F);
    chk("sw_wr_led", {8'h0, led_o}, 32'hA5A5A5);
    cpu_addr = 32'hFFFF_F078; #1;
    chk("btn_rd", cpu_rdata, 32'h15);
    // tube scan from a fresh reset phase
    rst_i = 1; #1; rst_i = 0;
    cpu_addr = 32'hFFFF_F000; cpu_wen = 1; cpu_wdata = 32'h87654321;
    tick();
    cpu_wen = 0;
    #1;
    chk("tube_rd", cpu_rdata, 32'h87654321);
    chk("scan_an0", {24'h0, dn_an_o}, 32'hFE);
    chk("scan_seg0", {24'h0, dn_seg_o}, 32'hF9);
    tick(); tick();
    chk("scan_an0_end", {24'h0, dn_an_o}, 32'hFE);
    tick();
    chk("scan_an1", {24'h0, dn_an_o}, {24'h0, an_tab[1]});
    chk("scan_seg1", {24'h0, dn_seg_o}, {24'h0, seg_tab[1]});
    for (int i = 2; i <= 8; i++) begin
      tick(); tick(); tick();
      chk("scan_hold", {24'h0, dn_an_o}, {24'h0, an_tab[i-1]});
      tick();
      chk("scan_an", {24'h0, dn_an_o}, {24'h0, an_tab[i]});
      chk("scan_seg", {24'h0, dn_seg_o}, {24'h0, seg_tab[i]});
    end
    // timer load and wrap
    cpu_addr = 32'hFFFF_F020; cpu_wen = 1; cpu_wdata = 32'hFFFF_FFFE;
    tick();
    cpu_wen = 0;
    #1;
    chk("tmr0", cpu_rdata, 32'hFFFF_FFFE);
    tick();
    chk("tmr1", cpu_rdata, 32'hFFFF_FFFF);
    tick();
    chk("tmr2", cpu_rdata, 32'h0);
    // asynchronous reset mid-scan
    cpu_addr = 32'hFFFF_F060; cpu_wen = 1; cpu_wdata = 32'h00123456;
    tick();
    cpu_wen = 0;
    repeat (5) tick();
    chk("pre_rst_led", {8'h0, led_o}, 32'h123456);
    chk("pre_rst_an_nz", {31'h0, dn_an_o != 8'hFE}, 32'h1);
    rst_i = 1;
    #1;
    chk("arst_led", {8'h0, led_o}, 32'h0);
    chk("arst_an", {24'h0, dn_an_o}, 32'hFE);
    chk("arst_seg", {24'h0, dn_seg_o}, 32'hC0);
    cpu_addr = 32'hFFFF_F020; #1;
    chk("arst_tmr", cpu_rdata, 32'h0);
    cpu_addr = 32'hFFFF_F000; #1;
    chk("arst_tube", cpu_rdata, 32'h0);
    cpu_addr = 32'hFFFF_F040; cpu_wen = 1; #1;
    chk("arst_we_follow", {31'h0, dram_we}, 32'h0);
    chk("unmapped_rd", cpu_rdata, 32'h0);
    cpu_addr = 32'h0000_0010; #1;
    chk("rst_dram_we", {31'h0, dram_we}, 32'h1);
    cpu_wen = 0;
    tick();
    rst_i = 0;
    cpu_addr = 32'hFFFF_F040; cpu_wen = 1; cpu_wdata = 32'hFFFF_FFFF;
    tick();
    cpu_wen = 0;
    #1;
    chk("unmapped_wr", cpu_rdata, 32'h0);
    chk("unmapped_led", {8'h0, led_o}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
